// File: rtl/arb_mux_if.sv
// arb_mux_if: channel-side and output-side signals of the arbitrating mux.
//   in_valid/in_data/in_last/in_ready : N request channels; data is flattened,
//                                        and channel i sits at [i*WIDTH +: WIDTH]
//   out_valid/out_data/out_last/out_sel/out_ready : single registered output beat
// Modports: master = traffic source/sink side (bench), slave = the mux itself.
interface arb_mux_if #(
  parameter int WIDTH = 16,
  parameter int N     = 8
);
  localparam int SELW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_last;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;
  logic [SELW-1:0]    out_sel;
  logic               out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel
  );
endinterface

// File: rtl/arb_mux.sv
// arb_mux: N-channel packet-aware arbiter feeding a single-entry output register.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : arb_mux_if.slave (request channels in, registered beat out)
// Arbitration is round-robin (PRIO_MODE=0) or fixed priority with channel 0
// highest (PRIO_MODE=1). Once a packet starts, the mux stays on that channel
// until its last beat, so packets never interleave. Latency is one cycle and
// a beat can be accepted every cycle while the downstream keeps out_ready high.
module arb_mux #(
  parameter int WIDTH     = 16,
  parameter int N         = 8,
  parameter int PRIO_MODE = 0,
  localparam int SELW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic     clk,
  input  logic     reset,
  arb_mux_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [SELW:0] N_W = (SELW+1)'(N);

  state_t           state_r;
  logic [SELW-1:0]  rr_ptr_r;
  logic [SELW-1:0]  lock_ch_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic             out_last_r;
  logic [SELW-1:0]  out_sel_r;

  logic             can_accept_s;
  logic             grant_valid_s;
  logic [SELW-1:0]  grant_idx_s;
  logic [WIDTH-1:0] grant_data_s;
  logic             grant_last_s;
  logic             xfer_s;
  logic [N-1:0]     in_ready_s;

  // Pick the granted channel: the open packet's channel, or a new winner in IDLE.
  always_comb begin
    logic [SELW:0] sum_v;
    logic [SELW:0] idx_v;
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    sum_v         = '0;
    idx_v         = '0;
    case (state_r)
      LOCKED: begin
        grant_idx_s   = lock_ch_r;
        grant_valid_s = bus.in_valid[lock_ch_r];
      end
      IDLE: begin
        if (PRIO_MODE == 1) begin
          // Scan downward so the lowest requesting index is the last one written.
          for (int i = N - 1; i >= 0; i--) begin
            grant_idx_s   = bus.in_valid[SELW'(i)] ? SELW'(i) : grant_idx_s;
            grant_valid_s = grant_valid_s | bus.in_valid[SELW'(i)];
          end
        end else begin
          // Offsets N..1 from rr_ptr; the smallest offset (rr_ptr+1) wins,
          // and offset N lands on rr_ptr itself, making it the last choice.
          for (int k = N; k >= 1; k--) begin
            sum_v         = {1'b0, rr_ptr_r} + (SELW+1)'(k);
            idx_v         = (sum_v >= N_W) ? (sum_v - N_W) : sum_v;
            grant_idx_s   = bus.in_valid[idx_v[SELW-1:0]] ? idx_v[SELW-1:0] : grant_idx_s;
            grant_valid_s = grant_valid_s | bus.in_valid[idx_v[SELW-1:0]];
          end
        end
      end
      default: begin
        grant_idx_s   = '0;
        grant_valid_s = 1'b0;
      end
    endcase
  end

  // Handshake qualification and data/last selection for the granted channel.
  always_comb begin
    can_accept_s = !out_valid_r || bus.out_ready;
    xfer_s       = can_accept_s && grant_valid_s && !reset;
    grant_last_s = bus.in_last[grant_idx_s];
    grant_data_s = '0;
    in_ready_s   = '0;
    for (int i = 0; i < N; i++) begin
      grant_data_s  = (grant_idx_s == SELW'(i)) ? bus.in_data[i*WIDTH +: WIDTH] : grant_data_s;
      in_ready_s[i] = xfer_s && (grant_idx_s == SELW'(i));
    end
  end

  // Packet FSM, round-robin pointer and the registered output beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      rr_ptr_r    <= SELW'(N - 1);
      lock_ch_r   <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      out_sel_r   <= '0;
    end else if (xfer_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= grant_data_s;
      out_last_r  <= grant_last_s;
      out_sel_r   <= grant_idx_s;
      // The pointer only moves at packet end, so fairness is per packet.
      case (state_r)
        IDLE: begin
          if (grant_last_s) begin
            rr_ptr_r <= grant_idx_s;
          end else begin
            state_r   <= LOCKED;
            lock_ch_r <= grant_idx_s;
          end
        end
        LOCKED: begin
          if (grant_last_s) begin
            state_r  <= IDLE;
            rr_ptr_r <= grant_idx_s;
          end else begin
            state_r <= LOCKED;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_sel   = out_sel_r;

endmodule
